// File: rtl/multdiv_pkg.sv
// +--------------------------------------------------------------------------+
// | multdiv_pkg : shared encodings for the mult/div issue stage              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package multdiv_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   localparam int DEFAULT_TIMEOUT = 40;

endpackage

`default_nettype wire

// File: rtl/multdiv_issue.sv
// +--------------------------------------------------------------------------+
// | multdiv_issue : issues one mult/div op, stalls until result or timeout   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module multdiv_issue
   import multdiv_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT,
   parameter int CW      = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic [4:0]  req_rd,
   output logic        ctrl_MULT,
   output logic        ctrl_DIV,
   output logic [31:0] data_operandA,
   output logic [31:0] data_operandB,
   input  logic [31:0] mult_result,
   input  logic [31:0] div_result,
   input  logic        mult_exception,
   input  logic        div_exception,
   input  logic        mult_resultRDY,
   input  logic        div_resultRDY,
   output logic        stall,
   output logic        wb_valid,
   output logic [31:0] wb_data,
   output logic        wb_exception,
   output logic [4:0]  wb_rd,
   input  logic        wb_ready
);

   // WAIT starts with the counter at 0, so the last allowed cycle holds TIMEOUT-1
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_e        state_q, state_d;
   logic          op_q, op_d;
   logic [31:0]   a_q, a_d;
   logic [31:0]   b_q, b_d;
   logic [4:0]    rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ctrl_mult_q, ctrl_mult_d;
   logic          ctrl_div_q, ctrl_div_d;
   logic          wb_valid_q, wb_valid_d;
   logic [31:0]   wb_data_q, wb_data_d;
   logic          wb_exc_q, wb_exc_d;

   logic          sel_rdy;
   logic [31:0]   sel_result;
   logic          sel_exc;

   always_comb begin
      sel_rdy    = (op_q == OP_DIV) ? div_resultRDY  : mult_resultRDY;
      sel_result = (op_q == OP_DIV) ? div_result     : mult_result;
      sel_exc    = (op_q == OP_DIV) ? div_exception  : mult_exception;
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      rd_d        = rd_q;
      cnt_d       = cnt_q;
      ctrl_mult_d = 1'b0;
      ctrl_div_d  = 1'b0;
      wb_valid_d  = wb_valid_q;
      wb_data_d   = wb_data_q;
      wb_exc_d    = wb_exc_q;

      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d = req_op;
               a_d  = req_a;
               b_d  = req_b;
               rd_d = req_rd;
               if (req_op == OP_DIV && req_b == 32'd0) begin
                  state_d    = S_DONE;
                  wb_valid_d = 1'b1;
                  wb_data_d  = 32'd0;
                  wb_exc_d   = 1'b1;
               end else begin
                  state_d     = S_ISSUE;
                  ctrl_mult_d = (req_op == OP_MULT);
                  ctrl_div_d  = (req_op == OP_DIV);
               end
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (sel_rdy) begin
               state_d    = S_DONE;
               wb_valid_d = 1'b1;
               wb_data_d  = sel_result;
               wb_exc_d   = sel_exc;
            end else if (cnt_q == CNT_LAST) begin
               state_d    = S_DONE;
               wb_valid_d = 1'b1;
               wb_data_d  = 32'd0;
               wb_exc_d   = 1'b1;
            end
         end
         S_DONE: begin
            if (wb_ready) begin
               state_d    = S_IDLE;
               wb_valid_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         op_q        <= OP_MULT;
         a_q         <= '0;
         b_q         <= '0;
         rd_q        <= '0;
         cnt_q       <= '0;
         ctrl_mult_q <= 1'b0;
         ctrl_div_q  <= 1'b0;
         wb_valid_q  <= 1'b0;
         wb_data_q   <= '0;
         wb_exc_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         rd_q        <= rd_d;
         cnt_q       <= cnt_d;
         ctrl_mult_q <= ctrl_mult_d;
         ctrl_div_q  <= ctrl_div_d;
         wb_valid_q  <= wb_valid_d;
         wb_data_q   <= wb_data_d;
         wb_exc_q    <= wb_exc_d;
      end
   end

   assign stall = ((state_q == S_IDLE) && req_valid)
                | (state_q == S_ISSUE)
                | (state_q == S_WAIT)
                | ((state_q == S_DONE) && !wb_ready);

   assign ctrl_MULT     = ctrl_mult_q;
   assign ctrl_DIV      = ctrl_div_q;
   assign data_operandA = a_q;
   assign data_operandB = b_q;
   assign wb_valid      = wb_valid_q;
   assign wb_data       = wb_data_q;
   assign wb_exception  = wb_exc_q;
   assign wb_rd         = rd_q;

endmodule

`default_nettype wire

// File: tb/tb_multdiv_issue.sv
// +--------------------------------------------------------------------------+
// | tb_multdiv_issue : directed self-checking bench for multdiv_issue        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_multdiv_issue;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_op;
   logic [31:0] req_a, req_b;
   logic [4:0]  req_rd;
   logic        ctrl_MULT, ctrl_DIV;
   logic [31:0] data_operandA, data_operandB;
   logic [31:0] mult_result, div_result;
   logic        mult_exception, div_exception;
   logic        mult_resultRDY, div_resultRDY;
   logic        stall;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic        wb_exception;
   logic [4:0]  wb_rd;
   logic        wb_ready;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   multdiv_issue #(.TIMEOUT(40), .CW(6)) dut (
      .clock          (clock),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_op         (req_op),
      .req_a          (req_a),
      .req_b          (req_b),
      .req_rd         (req_rd),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .mult_result    (mult_result),
      .div_result     (div_result),
      .mult_exception (mult_exception),
      .div_exception  (div_exception),
      .mult_resultRDY (mult_resultRDY),
      .div_resultRDY  (div_resultRDY),
      .stall          (stall),
      .wb_valid       (wb_valid),
      .wb_data        (wb_data),
      .wb_exception   (wb_exception),
      .wb_rd          (wb_rd),
      .wb_ready       (wb_ready)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic present(input logic op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_rd    = rd;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation watchdog expired");
   end

   initial begin
      int pulses, stall_lo, early, first, held_bad, vcnt;

      reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0; req_rd = '0;
      mult_result = '0; div_result = '0; mult_exception = 1'b0; div_exception = 1'b0;
      mult_resultRDY = 1'b0; div_resultRDY = 1'b0; wb_ready = 1'b1;
      tick(); tick();
      chk("rst_ctrl_mult", 32'(ctrl_MULT), 32'd0);
      chk("rst_ctrl_div", 32'(ctrl_DIV), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_exc", 32'(wb_exception), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_opA", data_operandA, 32'd0);
      chk("rst_wb_rd", 32'(wb_rd), 32'd0);
      reset = 1'b0;
      tick();

      // MULT 6 x 7, result after 16 cycles
      present(1'b0, 32'd6, 32'd7, 5'd5);
      #1 chk("mult_accept_stall", 32'(stall), 32'd1);
      tick();
      req_valid = 1'b0; req_a = '0; req_b = '0;
      chk("mult_pulse", 32'(ctrl_MULT), 32'd1);
      chk("mult_no_div", 32'(ctrl_DIV), 32'd0);
      chk("mult_opA", data_operandA, 32'd6);
      chk("mult_opB", data_operandB, 32'd7);
      pulses = 0; stall_lo = 0; early = 0;
      for (int c = 2; c <= 17; c++) begin
         tick();
         pulses += int'(ctrl_MULT) + int'(ctrl_DIV);
         if (!stall) stall_lo++;
         if (wb_valid) early++;
      end
      chk("mult_extra_pulses", 32'(pulses), 32'd0);
      chk("mult_stall_low", 32'(stall_lo), 32'd0);
      chk("mult_early_valid", 32'(early), 32'd0);
      mult_result = 32'd42; mult_resultRDY = 1'b1;
      tick();
      mult_resultRDY = 1'b0; mult_result = '0;
      chk("mult_wb_valid", 32'(wb_valid), 32'd1);
      chk("mult_wb_data", wb_data, 32'd42);
      chk("mult_wb_exc", 32'(wb_exception), 32'd0);
      chk("mult_wb_rd", 32'(wb_rd), 32'd5);
      tick();
      chk("mult_idle_valid", 32'(wb_valid), 32'd0);

      // back-to-back DIV 100 / 0
      present(1'b1, 32'd100, 32'd0, 5'd3);
      #1 chk("dz_accept_stall", 32'(stall), 32'd1);
      tick();
      req_valid = 1'b0;
      chk("dz_wb_valid", 32'(wb_valid), 32'd1);
      chk("dz_wb_data", wb_data, 32'd0);
      chk("dz_wb_exc", 32'(wb_exception), 32'd1);
      chk("dz_no_ctrl_div", 32'(ctrl_DIV), 32'd0);
      chk("dz_wb_rd", 32'(wb_rd), 32'd3);
      tick();
      chk("dz_idle_valid", 32'(wb_valid), 32'd0);
      chk("dz_no_pulse_later", 32'(ctrl_DIV), 32'd0);

      // DIV 7 / 3 with stale RDY, spurious mult RDY, and writeback backpressure
      present(1'b1, 32'd7, 32'd3, 5'd9);
      tick();
      req_valid = 1'b0;
      chk("div_pulse", 32'(ctrl_DIV), 32'd1);
      chk("div_no_mult", 32'(ctrl_MULT), 32'd0);
      div_result = 32'd99; div_resultRDY = 1'b1;
      tick();
      div_resultRDY = 1'b0;
      chk("div_stale_rdy", 32'(wb_valid), 32'd0);
      chk("div_pulse_end", 32'(ctrl_DIV), 32'd0);
      mult_result = 32'd123; mult_resultRDY = 1'b1;
      tick();
      mult_resultRDY = 1'b0;
      chk("div_spurious_mult", 32'(wb_valid), 32'd0);
      tick(); tick(); tick();
      chk("div_opA_held", data_operandA, 32'd7);
      chk("div_opB_held", data_operandB, 32'd3);
      chk("div_wait_stall", 32'(stall), 32'd1);
      div_result = 32'd2; div_resultRDY = 1'b1; wb_ready = 1'b0;
      tick();
      div_resultRDY = 1'b0; div_result = 32'd55;
      chk("div_wb_valid", 32'(wb_valid), 32'd1);
      chk("div_wb_data", wb_data, 32'd2);
      chk("div_wb_exc", 32'(wb_exception), 32'd0);
      chk("div_wb_rd", 32'(wb_rd), 32'd9);
      held_bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (!(wb_valid === 1'b1 && wb_data === 32'd2 && stall === 1'b1)) held_bad++;
      end
      chk("div_backpressure_hold", 32'(held_bad), 32'd0);
      wb_ready = 1'b1;
      #1 chk("div_release_stall", 32'(stall), 32'd0);
      tick();
      chk("div_idle_valid", 32'(wb_valid), 32'd0);

      // DIV with unit never responding
      present(1'b1, 32'd50, 32'd5, 5'd7);
      tick();
      req_valid = 1'b0;
      first = 0;
      for (int c = 2; c <= 60; c++) begin
         tick();
         if (wb_valid) begin
            first = c;
            break;
         end
      end
      chk("to_latency", 32'(first), 32'd42);
      chk("to_wb_data", wb_data, 32'd0);
      chk("to_wb_exc", 32'(wb_exception), 32'd1);
      chk("to_wb_rd", 32'(wb_rd), 32'd7);
      tick();

      // reset during WAIT cycle 10
      present(1'b1, 32'd8, 32'd2, 5'd11);
      tick();
      req_valid = 1'b0;
      for (int c = 2; c <= 10; c++) tick();
      chk("rstw_stall_before", 32'(stall), 32'd1);
      reset = 1'b1;
      tick();
      chk("rstw_ctrl_div", 32'(ctrl_DIV), 32'd0);
      chk("rstw_stall", 32'(stall), 32'd0);
      chk("rstw_wb_valid", 32'(wb_valid), 32'd0);
      chk("rstw_wb_exc", 32'(wb_exception), 32'd0);
      chk("rstw_opA", data_operandA, 32'd0);
      chk("rstw_opB", data_operandB, 32'd0);
      chk("rstw_wb_rd", 32'(wb_rd), 32'd0);
      reset = 1'b0;
      div_result = 32'd9; div_resultRDY = 1'b1;
      vcnt = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (wb_valid !== 1'b0) vcnt++;
      end
      div_resultRDY = 1'b0;
      chk("rstw_late_rdy", 32'(vcnt), 32'd0);

      // MULT with unit exception passing through
      present(1'b0, 32'd3, 32'd4, 5'd2);
      tick();
      req_valid = 1'b0;
      tick();
      mult_result = 32'd12; mult_exception = 1'b1; mult_resultRDY = 1'b1;
      tick();
      mult_resultRDY = 1'b0; mult_exception = 1'b0;
      chk("mexc_wb_valid", 32'(wb_valid), 32'd1);
      chk("mexc_wb_data", wb_data, 32'd12);
      chk("mexc_wb_exc", 32'(wb_exception), 32'd1);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/multdiv_issue.md
# multdiv_issue

Issue/control stage sitting directly upstream of the iterative multiplier and divider in the execute stage. Accepts one mult/div request from the pipeline, latches operands, fires a single-cycle `ctrl_MULT`/`ctrl_DIV` start pulse, stalls the pipeline while the selected unit iterates, then presents the captured result and exception for writeback. Adds early divide-by-zero detection and a watchdog timeout so a hung unit cannot deadlock the pipeline.

## Interface
- `TIMEOUT`, 40: max WAIT cycles before forced exception (must exceed divider latency).
- `CW`, 6: wait-counter width; `2**CW > TIMEOUT`.
- One clock; reset is synchronous and active-high.
- `clock` in 1: sole clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: pipeline presents a mult/div instruction.
- `req_op` in 1: 0 = MULT, 1 = DIV.
- `req_a`, `req_b` in 32 each: operands A, B.
- `req_rd` in 5: destination register tag.
- `ctrl_MULT`, `ctrl_DIV` out 1 each: start pulses to units.
- `data_operandA`, `data_operandB` out 32 each: registered operands to both units.
- `mult_result`, `div_result` in 32 each; `mult_exception`, `div_exception`, `mult_resultRDY`, `div_resultRDY` in 1 each.
- `stall` out 1: hold upstream pipeline.
- `wb_valid` out 1; `wb_data` out 32; `wb_exception` out 1; `wb_rd` out 5: writeback payload.
- `wb_ready` in 1: writeback accepts payload.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: on `req_valid`, latch `req_op`, `req_a`, `req_b`, `req_rd`. If DIV and `req_b == 0` -> DONE with `wb_data = 0`, `wb_exception = 1` (no unit issued). Else -> ISSUE.
- ISSUE: assert exactly one of `ctrl_MULT`/`ctrl_DIV` per latched op for this one cycle; clear counter -> WAIT.
- WAIT: counter += 1 each cycle. On `resultRDY` of the selected unit, capture its result/exception -> DONE. The other unit's `resultRDY` is ignored. If counter reaches `TIMEOUT` first -> DONE with `wb_data = 0`, `wb_exception = 1`. Simultaneous RDY and timeout: RDY wins.
- DONE: `wb_valid = 1`, payload stable; on `wb_ready` -> IDLE.
- `stall = (IDLE & req_valid) | ISSUE | WAIT | (DONE & ~wb_ready)`; combinational.
- `req_valid` outside IDLE is ignored (pipeline is stalled).
- `data_operandA/B` change only on latch in IDLE; stable through ISSUE and WAIT.
- No arithmetic here; signedness and overflow belong to the units, and their exception flags pass through unchanged.

## Timing
- Reset: state IDLE; `ctrl_MULT`, `ctrl_DIV`, `stall`, `wb_valid`, `wb_exception` = 0; `wb_data`, `data_operandA/B`, `wb_rd`, counter = 0.
- Request accepted at cycle 0 -> start pulse at cycle 1 -> WAIT from cycle 2. RDY sampled at cycle k -> `wb_valid` at k+1.
- Divide-by-zero: request at cycle 0 -> `wb_valid` at cycle 1.
- Timeout: `wb_valid` at cycle 2 + `TIMEOUT`.
- `resultRDY` asserted during ISSUE (stale from a prior op) is ignored.
- Reset mid-operation returns to IDLE next edge. A unit's later RDY is ignored because IDLE does not sample it.
- Back-to-back: with `wb_ready` high in DONE, a new `req_valid` is accepted in the following IDLE cycle.

## Structure
- Shared package `multdiv_pkg`: state encoding (IDLE/ISSUE/WAIT/DONE), op encoding (OP_MULT = 0, OP_DIV = 1), default `TIMEOUT`.
- Single module. Counter stays inline; no sub-module warranted.

## Test plan
- MULT 6 x 7, stub RDY after 16 cycles -> one `ctrl_MULT` pulse at cycle 1; `wb_data = 42`, `wb_exception = 0`, `wb_valid` 1 cycle after RDY; `stall` high throughout.
- DIV 7 / 3 with the real divider -> single `ctrl_DIV` pulse; `wb_data = 2`; `data_operandA/B` held at 7/3 until DONE.
- DIV 100 / 0 -> no `ctrl_DIV`; `wb_valid` at cycle 1 with `wb_data = 0`, `wb_exception = 1`.
- DIV with stub never asserting RDY -> `wb_exception = 1`, `wb_data = 0`, `wb_valid` at cycle 42 (`TIMEOUT` 40).
- `wb_ready` low 5 cycles in DONE -> payload and `stall` held; IDLE the cycle after `wb_ready`; spurious `mult_resultRDY` during a DIV op ignored.
- `reset` pulsed in WAIT cycle 10 -> all outputs 0 next edge; a later `div_resultRDY` produces no `wb_valid`.
